// File: rtl/gpin_pkg.sv
// gpin_pkg: shared constants for the general-purpose input conditioner.
// Register word indices and the default glitch-filter length.
package gpin_pkg;

  localparam logic [1:0] GPIN_LEVEL = 2'd0;
  localparam logic [1:0] GPIN_MASK  = 2'd1;
  localparam logic [1:0] GPIN_PEND  = 2'd2;
  localparam logic [1:0] GPIN_RAW   = 2'd3;

  localparam int GPIN_FILT_DEF = 4;

endpackage

// File: rtl/gpin_filter_bit.sv
// gpin_filter_bit: one input bit -- 2-flop synchroniser, stability filter,
// registered level and rise/fall pulses derived from the filtered level.
// Ports: clk, reset (sync, active-high), i_pin (async pin),
//        o_s2 (synchronised raw), o_level (filtered), o_rise, o_fall.
module gpin_filter_bit
  import gpin_pkg::*;
#(
  parameter int FILT = GPIN_FILT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_s2,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(FILT + 1);
  localparam logic [CW-1:0] LAST = CW'(FILT - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_s1      <= i_pin;
      r_s2      <= r_s1;
      r_level_d <= r_level;
      // any sample agreeing with level restarts the count
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_s2    = r_s2;
  assign o_level = r_level;
  assign o_rise  = r_level & ~r_level_d;
  assign o_fall  = ~r_level & r_level_d;

endmodule

// File: rtl/gpin_conditioner.sv
// gpin_conditioner: conditions N async pins into clean levels, latches
// edges into W1C pending flags and drives a maskable registered irq.
// Ports: clk, reset, pin_in[N], level[N], cs, we, addr[2], wdata[32],
//        rdata[32] (combinational read), irq.
module gpin_conditioner
  import gpin_pkg::*;
#(
  parameter int N    = 2,
  parameter int FILT = GPIN_FILT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  pin_in,
  output logic [N-1:0]  level,
  input  logic          cs,
  input  logic          we,
  input  logic [1:0]    addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          irq
);

  localparam int W2 = 2 * N;

  logic [N-1:0]  w_s2;
  logic [N-1:0]  w_rise;
  logic [N-1:0]  w_fall;
  logic          w_wr;
  logic          w_wr_mask;
  logic [W2-1:0] w_clr;

  logic [W2-1:0] r_pend;
  logic [W2-1:0] r_mask;
  logic          r_irq;

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    gpin_filter_bit #(
      .FILT(FILT)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .i_pin  (pin_in[gi]),
      .o_s2   (w_s2[gi]),
      .o_level(level[gi]),
      .o_rise (w_rise[gi]),
      .o_fall (w_fall[gi])
    );
  end

  if (W2 < 32) begin : g_unused
    logic w_unused;
    assign w_unused = ^wdata[31:W2];
  end

  assign w_wr      = cs & we;
  assign w_wr_mask = w_wr && (addr == GPIN_MASK);
  assign w_clr     = (w_wr && (addr == GPIN_PEND))
                     ? wdata[W2-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      // set is OR-ed after the clear so a same-cycle event wins
      r_pend <= (r_pend & ~w_clr) | {w_fall, w_rise};
      if (w_wr_mask) begin
        r_mask <= wdata[W2-1:0];
      end
      r_irq <= |(r_pend & r_mask);
    end
  end

  assign irq = r_irq;

  always_comb begin
    rdata = '0;
    if (cs) begin
      unique case (addr)
        GPIN_LEVEL: rdata[N-1:0]  = level;
        GPIN_MASK:  rdata[W2-1:0] = r_mask;
        GPIN_PEND:  rdata[W2-1:0] = r_pend;
        GPIN_RAW:   rdata[N-1:0]  = w_s2;
      endcase
    end
  end

endmodule

// File: tb/tb_gpin_conditioner.sv
// tb_gpin_conditioner: directed scenarios plus randomized traffic checked
// against a behavioural model of the conditioner.
module tb_gpin_conditioner;

  localparam int N    = 2;
  localparam int FILT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  pin_in = '0;
  logic [N-1:0]  level;
  logic          cs = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    addr = 2'd0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          irq;

  int n_checks = 0;
  int n_err = 0;

  gpin_conditioner #(
    .N(N),
    .FILT(FILT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pin_in(pin_in),
    .level (level),
    .cs    (cs),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // behavioural model: level follows the synchronised pin once it has
  // disagreed with level for FILT consecutive samples
  logic [N-1:0]   m_s1 = '0, m_s2 = '0, m_lvl = '0, m_lvl_d = '0;
  logic [2*N-1:0] m_pend = '0, m_mask = '0;
  logic           m_irq = 1'b0;
  int             m_streak [N];

  always @(posedge clk) begin
    logic [N-1:0]   nl;
    logic [2*N-1:0] clr;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_d = '0;
      m_pend = '0; m_mask = '0; m_irq = 1'b0;
      for (int i = 0; i < N; i++) m_streak[i] = 0;
    end else begin
      nl = m_lvl;
      for (int i = 0; i < N; i++) begin
        if (m_s2[i] != m_lvl[i]) m_streak[i]++;
        else m_streak[i] = 0;
        if (m_streak[i] >= FILT) begin
          nl[i] = m_s2[i];
          m_streak[i] = 0;
        end
      end
      clr = (cs && we && addr == 2'd2) ? wdata[2*N-1:0] : '0;
      m_irq = |(m_pend & m_mask);
      m_pend = (m_pend & ~clr)
             | {~m_lvl & m_lvl_d, m_lvl & ~m_lvl_d};
      if (cs && we && addr == 2'd1) m_mask = wdata[2*N-1:0];
      m_lvl_d = m_lvl;
      m_lvl = nl;
      m_s2 = m_s1;
      m_s1 = pin_in;
    end
  end

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[N-1:0] = m_lvl;
      2'd1: r[2*N-1:0] = m_mask;
      2'd2: r[2*N-1:0] = m_pend;
      default: r[N-1:0] = m_s2;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    cs = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_checks++;
    if (level !== 2'b00) begin
      n_err++; $display("FAIL reset_level: got %h want 0", level);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL reset_irq: got %b want 0", irq);
    end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      n_checks++;
      if (d !== 32'h0) begin
        n_err++; $display("FAIL reset_read%0d: got %h want 0", a, d);
      end
    end
  endtask

  task automatic test_rise_irq();
    logic [31:0] d;
    wr(2'd1, 32'h1);
    @(negedge clk);
    pin_in[0] = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (level !== 2'b00) begin
      n_err++; $display("FAIL rise_k4_level: got %h want 0", level);
    end
    tick();
    rd(2'd2, d);
    n_checks++;
    if (level !== 2'b01 || d !== 32'h0) begin
      n_err++;
      $display("FAIL rise_k5: level %h pend %h want 1/0", level, d);
    end
    tick();
    rd(2'd2, d);
    n_checks++;
    if (d !== 32'h1 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL rise_k6: pend %h irq %b want 1/0", d, irq);
    end
    tick();
    n_checks++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL rise_k7_irq: got %b want 1", irq);
    end
    wr(2'd2, 32'h1);
    rd(2'd2, d);
    n_checks++;
    if (d !== 32'h0 || irq !== 1'b1) begin
      n_err++;
      $display("FAIL w1c_w: pend %h irq %b want 0/1", d, irq);
    end
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL w1c_w1_irq: got %b want 0", irq);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    @(negedge clk);
    pin_in[1] = 1'b1;
    repeat (3) @(negedge clk);
    pin_in[1] = 1'b0;
    repeat (12) tick();
    rd(2'd2, d);
    n_checks++;
    if (level !== 2'b01 || d !== 32'h0) begin
      n_err++;
      $display("FAIL glitch3: level %h pend %h want 1/0", level, d);
    end
    @(negedge clk);
    pin_in[1] = 1'b1;
    repeat (4) @(negedge clk);
    pin_in[1] = 1'b0;
    repeat (4) tick();
    rd(2'd2, d);
    n_checks++;
    if (d !== 32'h2) begin
      n_err++; $display("FAIL pulse4_rise: pend %h want 2", d);
    end
    repeat (8) tick();
    rd(2'd2, d);
    n_checks++;
    if (d !== 32'hA) begin
      n_err++; $display("FAIL pulse4_fall: pend %h want a", d);
    end
    wr(2'd2, 32'hF);
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d;
    @(negedge clk);
    pin_in[0] = 1'b0;
    repeat (12) tick();
    wr(2'd2, 32'hF);
    @(negedge clk);
    pin_in[0] = 1'b1;
    repeat (6) @(posedge clk);
    wr(2'd2, 32'h1);
    rd(2'd2, d);
    n_checks++;
    if (d !== 32'h1) begin
      n_err++; $display("FAIL collide_pend: got %h want 1", d);
    end
    tick();
    n_checks++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL collide_irq1: got %b want 1", irq);
    end
    tick();
    rd(2'd2, d);
    n_checks++;
    if (irq !== 1'b1 || d !== 32'h1) begin
      n_err++;
      $display("FAIL collide_hold: irq %b pend %h want 1/1", irq, d);
    end
  endtask

  task automatic test_mask_fall();
    logic [31:0] d;
    wr(2'd1, 32'h0);
    wr(2'd2, 32'hF);
    @(negedge clk);
    pin_in[0] = 1'b0;
    repeat (12) tick();
    rd(2'd2, d);
    n_checks++;
    if (d !== 32'h4 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL fall_nomask: pend %h irq %b want 4/0", d, irq);
    end
    wr(2'd1, 32'hC);
    n_checks++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL mask_w_irq: got %b want 0", irq);
    end
    tick();
    n_checks++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL mask_w1_irq: got %b want 1", irq);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    @(negedge clk);
    pin_in[0] = 1'b1;
    repeat (12) tick();
    rd(2'd2, d);
    n_checks++;
    if (d !== 32'h5) begin
      n_err++; $display("FAIL pre_reset_pend: got %h want 5", d);
    end
    @(negedge clk);
    pin_in[1] = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    tick();
    n_checks++;
    if (level !== 2'b00 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: level %h irq %b want 0/0", level, irq);
    end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      n_checks++;
      if (d !== 32'h0) begin
        n_err++; $display("FAIL mid_reset_read%0d: got %h want 0", a, d);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (level !== 2'b00) begin
      n_err++; $display("FAIL restart_k4: level %h want 0", level);
    end
    tick();
    n_checks++;
    if (level !== 2'b11) begin
      n_err++; $display("FAIL restart_k5: level %h want 3", level);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] exp;
    logic [1:0]  a;
    int          r;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) pin_in[i] = ~pin_in[i];
      reset = ($urandom_range(0, 399) == 0);
      r = $urandom_range(0, 9);
      cs = (r < 2);
      we = (r < 2);
      addr = (r == 0) ? 2'd1 : 2'd2;
      wdata = $urandom;
      @(posedge clk);
      #1;
      n_checks++;
      if (level !== m_lvl || irq !== m_irq) begin
        n_err++;
        $display("FAIL rand_out c%0d: level %h irq %b want %h %b",
                 c, level, irq, m_lvl, m_irq);
      end
      a = 2'($urandom_range(0, 3));
      rd(a, d);
      exp = m_read(a);
      n_checks++;
      if (d !== exp) begin
        n_err++;
        $display("FAIL rand_read c%0d a%0d: got %h want %h", c, a, d, exp);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    cs = 1'b0;
    we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rise_irq();
    test_glitch();
    test_w1c_collision();
    test_mask_fall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
